// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-port SRAM arbiter.
package sram_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } sarb_state_e;

  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_DBG  = 1'b1;

  // Access-cycle counter width; bounds ACC_CYCLES to 1..15.
  localparam int CNT_W = 4;

endpackage

// File: rtl/sram_arb_rr.sv
// Two-way request picker: round-robin against the last owner, or port 1
// always winning ties when fixed priority is selected.
module sram_arb_rr
  import sram_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  input  logic       fixed,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  always_comb begin
    gnt_valid = |req;
    gnt_idx   = PORT_CORE;
    case (req)
      2'b01:   gnt_idx = PORT_CORE;
      2'b10:   gnt_idx = PORT_DBG;
      2'b11:   gnt_idx = fixed ? PORT_DBG : ~last;
      default: gnt_idx = PORT_CORE;
    endcase
  end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one async SRAM between the core (port 0) and JTAG debug (port 1);
// one latched access at a time, sram_en held for ACC_CYCLES, then an ack.
//
//  state     | meaning
//  ST_IDLE   | waiting for a request; arbitrates and latches the winner
//  ST_ACCESS | sram_en high, counter running down to terminal count
//  ST_DONE   | owner's ack pulses with read data, bus released
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int ACC_CYCLES = 1,
  parameter int FIXED_PRIO = 0
) (
  input  logic              sarb_clk,
  input  logic              sarb_rst,
  input  logic              p0_req,
  input  logic              p0_wr,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_ack,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_wr,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_ack,
  output logic [DATA_W-1:0] p1_rdata,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  output logic              sram_oe,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              sram_wr,
  output logic              sram_en,
  output logic              sarb_busy,
  output logic              sarb_owner
);

  if (ACC_CYCLES < 1 || ACC_CYCLES > 15) begin : g_acc_range_error
    $error("sram_arbiter: ACC_CYCLES must be in 1..15");
  end

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACC_CYCLES - 1);

  sarb_state_e      state;
  logic [CNT_W-1:0] cnt;
  logic             gnt_valid;
  logic             gnt_idx;

  sram_arb_rr u_rr (
    .req       ({p1_req, p0_req}),
    .last      (sarb_owner),
    .fixed     (FIXED_PRIO != 0),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  always_ff @(posedge sarb_clk) begin
    if (sarb_rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      sram_en    <= 1'b0;
      sram_wr    <= 1'b0;
      sram_oe    <= 1'b0;
      sram_addr  <= '0;
      sram_wdata <= '0;
      p0_ack     <= 1'b0;
      p1_ack     <= 1'b0;
      p0_rdata   <= '0;
      p1_rdata   <= '0;
      sarb_busy  <= 1'b0;
      sarb_owner <= PORT_DBG;
    end else begin
      p0_ack <= 1'b0;
      p1_ack <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (gnt_valid) begin
            state      <= ST_ACCESS;
            sarb_busy  <= 1'b1;
            sarb_owner <= gnt_idx;
            cnt        <= CNT_LOAD;
            sram_en    <= 1'b1;
            sram_addr  <= (gnt_idx == PORT_DBG) ? p1_addr  : p0_addr;
            sram_wdata <= (gnt_idx == PORT_DBG) ? p1_wdata : p0_wdata;
            sram_wr    <= (gnt_idx == PORT_DBG) ? p1_wr    : p0_wr;
            sram_oe    <= (gnt_idx == PORT_DBG) ? p1_wr    : p0_wr;
          end
        end
        ST_ACCESS: begin
          if (cnt == '0) begin
            state   <= ST_DONE;
            sram_en <= 1'b0;
            sram_wr <= 1'b0;
            sram_oe <= 1'b0;
            // Writes leave the owner's rdata register untouched.
            if (!sram_wr) begin
              if (sarb_owner == PORT_DBG) p1_rdata <= sram_rdata;
              else                        p0_rdata <= sram_rdata;
            end
            if (sarb_owner == PORT_DBG) p1_ack <= 1'b1;
            else                        p0_ack <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_DONE: begin
          state     <= ST_IDLE;
          sarb_busy <= 1'b0;
        end
        default: begin
          state     <= ST_IDLE;
          sarb_busy <= 1'b0;
          sram_en   <= 1'b0;
          sram_wr   <= 1'b0;
          sram_oe   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: instance 0 is ACC_CYCLES=3 round-robin,
// instance 1 is ACC_CYCLES=1 fixed priority; each has its own SRAM model.
module tb_sram_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst [2];
  logic        p0_req [2], p0_wr [2], p0_ack [2];
  logic [15:0] p0_addr [2], p0_wdata [2], p0_rdata [2];
  logic        p1_req [2], p1_wr [2], p1_ack [2];
  logic [15:0] p1_addr [2], p1_wdata [2], p1_rdata [2];
  logic [15:0] sram_addr [2], sram_wdata [2], sram_rdata [2];
  logic        sram_oe [2], sram_wr [2], sram_en [2], busy [2], owner [2];

  int n_chk  = 0;
  int n_pass = 0;

  function automatic logic [15:0] pattern(input logic [15:0] a);
    return a ^ 16'hBEFF;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    sram_arbiter #(
      .ADDR_W(16), .DATA_W(16),
      .ACC_CYCLES(g == 0 ? 3 : 1),
      .FIXED_PRIO(g == 0 ? 0 : 1)
    ) u_dut (
      .sarb_clk(clk), .sarb_rst(rst[g]),
      .p0_req(p0_req[g]), .p0_wr(p0_wr[g]), .p0_addr(p0_addr[g]), .p0_wdata(p0_wdata[g]),
      .p0_ack(p0_ack[g]), .p0_rdata(p0_rdata[g]),
      .p1_req(p1_req[g]), .p1_wr(p1_wr[g]), .p1_addr(p1_addr[g]), .p1_wdata(p1_wdata[g]),
      .p1_ack(p1_ack[g]), .p1_rdata(p1_rdata[g]),
      .sram_addr(sram_addr[g]), .sram_wdata(sram_wdata[g]), .sram_oe(sram_oe[g]),
      .sram_rdata(sram_rdata[g]), .sram_wr(sram_wr[g]), .sram_en(sram_en[g]),
      .sarb_busy(busy[g]), .sarb_owner(owner[g])
    );

    logic [15:0] mem [0:65535];
    initial for (int i = 0; i < 65536; i++) mem[i] = pattern(16'(i));
    always @(posedge clk) if (sram_en[g] && sram_wr[g]) mem[sram_addr[g]] = sram_wdata[g];
    assign sram_rdata[g] = mem[sram_addr[g]];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic get_ack(input int k, input bit p);
    return p ? p1_ack[k] : p0_ack[k];
  endfunction

  function automatic logic [15:0] get_rdata(input int k, input bit p);
    return p ? p1_rdata[k] : p0_rdata[k];
  endfunction

  task automatic set_req(input int k, input bit p, input bit req, input bit wr,
                         input logic [15:0] addr, input logic [15:0] wdata);
    if (p) begin
      p1_req[k] = req; p1_wr[k] = wr; p1_addr[k] = addr; p1_wdata[k] = wdata;
    end else begin
      p0_req[k] = req; p0_wr[k] = wr; p0_addr[k] = addr; p0_wdata[k] = wdata;
    end
  endtask

  // One isolated transaction; observes the SRAM bus until the ack arrives.
  task automatic do_txn(input int k, input bit p, input bit wr, input logic [15:0] addr,
                        input logic [15:0] wdata, output int lat, output int en_cyc,
                        output bit bus_ok, output logic [15:0] rd);
    lat = -1; en_cyc = 0; bus_ok = 1'b1; rd = 16'hxxxx;
    set_req(k, p, 1'b1, wr, addr, wdata);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if ((sram_oe[k] || sram_wr[k]) && !sram_en[k]) bus_ok = 1'b0;
      if (sram_en[k]) begin
        en_cyc++;
        if (sram_addr[k] !== addr || sram_wr[k] !== wr || sram_oe[k] !== wr ||
            (wr && sram_wdata[k] !== wdata)) bus_ok = 1'b0;
      end
      if (get_ack(k, !p)) bus_ok = 1'b0;
      if (get_ack(k, p)) begin
        lat = c;
        rd  = get_rdata(k, p);
        break;
      end
    end
    set_req(k, p, 1'b0, 1'b0, 16'h0, 16'h0);
    @(negedge clk);
    check("ack_single_pulse", get_ack(k, p), 0);
    check("busy_after_done", busy[k], 0);
  endtask

  typedef struct {
    int          k;
    bit          p;
    bit          wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rd;
    int          exp_lat;
    int          exp_en;
  } vec_t;

  vec_t vt [10];

  function automatic logic [15:0] ref_rd(input logic [15:0] a, ref logic [15:0] m [int]);
    return m.exists(int'(a)) ? m[int'(a)] : pattern(a);
  endfunction

  initial begin
    int          lat, en_cyc, n;
    bit          bus_ok, ovl, addr_held;
    logic [15:0] rd;
    int          tm [4];
    bit          pt [4];
    bit          exp_pt [4];
    int          exp_tm [4];
    bit          pend [2], rwr [2];
    logic [15:0] raddr [2], rwd [2], last_rd [2], exp_v;
    int          age [2];
    logic [15:0] ref_mem [int];

    vt[0] = '{1, 0, 0, 16'h0010, 16'h0000, 16'hBEEF, 2, 1};
    vt[1] = '{0, 1, 1, 16'hFFFF, 16'h1234, 16'h0000, 4, 3};
    vt[2] = '{0, 1, 0, 16'hFFFF, 16'h0000, 16'h1234, 4, 3};
    vt[3] = '{0, 1, 1, 16'h0100, 16'hA5A5, 16'h1234, 4, 3};
    vt[4] = '{0, 0, 0, 16'h0100, 16'h0000, 16'hA5A5, 4, 3};
    vt[5] = '{1, 1, 0, 16'h0020, 16'h0000, 16'hBEDF, 2, 1};
    vt[6] = '{1, 1, 1, 16'h0020, 16'h5A5A, 16'hBEDF, 2, 1};
    vt[7] = '{1, 0, 0, 16'h0020, 16'h0000, 16'h5A5A, 2, 1};
    vt[8] = '{0, 0, 1, 16'h0000, 16'hFFFF, 16'hA5A5, 4, 3};
    vt[9] = '{0, 0, 0, 16'h0000, 16'h0000, 16'hFFFF, 4, 3};

    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1;
      set_req(k, 0, 0, 0, 16'h0, 16'h0);
      set_req(k, 1, 0, 0, 16'h0, 16'h0);
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("rst%0d_en", k), sram_en[k], 0);
      check($sformatf("rst%0d_wr_oe", k), {sram_wr[k], sram_oe[k]}, 0);
      check($sformatf("rst%0d_addr_wdata", k), {sram_addr[k], sram_wdata[k]}, 0);
      check($sformatf("rst%0d_acks", k), {p0_ack[k], p1_ack[k]}, 0);
      check($sformatf("rst%0d_rdata", k), {p0_rdata[k], p1_rdata[k]}, 0);
      check($sformatf("rst%0d_busy", k), busy[k], 0);
      check($sformatf("rst%0d_owner", k), owner[k], 1);
      rst[k] = 1'b0;
    end
    @(negedge clk);

    // Table of isolated transactions.
    for (int i = 0; i < 10; i++) begin
      do_txn(vt[i].k, vt[i].p, vt[i].wr, vt[i].addr, vt[i].wdata, lat, en_cyc, bus_ok, rd);
      check($sformatf("v%0d_latency", i), lat, vt[i].exp_lat);
      check($sformatf("v%0d_en_cycles", i), en_cyc, vt[i].exp_en);
      check($sformatf("v%0d_bus", i), bus_ok, 1);
      check($sformatf("v%0d_rdata", i), rd, vt[i].exp_rd);
    end

    // Round-robin with both requests held; last instance-0 grant was port 0.
    exp_pt = '{1, 0, 1, 0};
    exp_tm = '{4, 9, 14, 19};
    set_req(0, 0, 1, 0, 16'h0200, 16'h0);
    set_req(0, 1, 1, 0, 16'h0300, 16'h0);
    n = 0; ovl = 1'b0;
    for (int c = 1; c <= 60 && n < 4; c++) begin
      @(negedge clk);
      if (p0_ack[0] && p1_ack[0]) ovl = 1'b1;
      if (p0_ack[0] || p1_ack[0]) begin pt[n] = p1_ack[0]; tm[n] = c; n++; end
    end
    set_req(0, 0, 0, 0, 16'h0, 16'h0);
    set_req(0, 1, 0, 0, 16'h0, 16'h0);
    @(negedge clk);
    check("rr_ack_count", n, 4);
    check("rr_no_overlap", ovl, 0);
    for (int i = 0; i < n; i++) begin
      check($sformatf("rr_port%0d", i), pt[i], exp_pt[i]);
      check($sformatf("rr_time%0d", i), tm[i], exp_tm[i]);
    end

    // Fixed priority: port 1 keeps winning until it drops its request.
    exp_pt = '{1, 1, 1, 0};
    exp_tm = '{2, 5, 8, 11};
    set_req(1, 0, 1, 0, 16'h0400, 16'h0);
    set_req(1, 1, 1, 0, 16'h0500, 16'h0);
    n = 0; ovl = 1'b0;
    for (int c = 1; c <= 60 && n < 4; c++) begin
      @(negedge clk);
      if (p0_ack[1] && p1_ack[1]) ovl = 1'b1;
      if (p0_ack[1] || p1_ack[1]) begin
        pt[n] = p1_ack[1]; tm[n] = c; n++;
        if (n == 3) set_req(1, 1, 0, 0, 16'h0, 16'h0);
      end
    end
    set_req(1, 0, 0, 0, 16'h0, 16'h0);
    @(negedge clk);
    check("fix_ack_count", n, 4);
    check("fix_no_overlap", ovl, 0);
    for (int i = 0; i < n; i++) begin
      check($sformatf("fix_port%0d", i), pt[i], exp_pt[i]);
      check($sformatf("fix_time%0d", i), tm[i], exp_tm[i]);
    end

    // Address change after latch must not reach the SRAM.
    set_req(0, 0, 1, 0, 16'h0001, 16'h0);
    lat = -1; en_cyc = 0; addr_held = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (sram_en[0]) begin
        en_cyc++;
        if (sram_addr[0] !== 16'h0001) addr_held = 1'b0;
      end
      if (c == 1) p0_addr[0] = 16'h0002;
      if (p0_ack[0]) begin lat = c; rd = p0_rdata[0]; break; end
    end
    set_req(0, 0, 0, 0, 16'h0, 16'h0);
    @(negedge clk);
    check("latch_addr_held", addr_held, 1);
    check("latch_en_cycles", en_cyc, 3);
    check("latch_latency", lat, 4);
    check("latch_rdata", rd, 16'hBEFE);

    // Reset in the second ACCESS cycle abandons the access.
    set_req(0, 1, 1, 0, 16'h0030, 16'h0);
    @(negedge clk);
    check("rst_mid_en_c1", sram_en[0], 1);
    @(negedge clk);
    check("rst_mid_en_c2", sram_en[0], 1);
    rst[0] = 1'b1;
    @(negedge clk);
    check("rst_mid_en_off", sram_en[0], 0);
    check("rst_mid_busy", busy[0], 0);
    check("rst_mid_owner", owner[0], 1);
    rst[0] = 1'b0;
    set_req(0, 1, 0, 0, 16'h0, 16'h0);
    n = 0;
    if (p0_ack[0] || p1_ack[0]) n++;
    repeat (6) begin
      @(negedge clk);
      if (p0_ack[0] || p1_ack[0]) n++;
    end
    check("rst_mid_no_ack", n, 0);
    do_txn(0, 0, 0, 16'h0040, 16'h0, lat, en_cyc, bus_ok, rd);
    check("post_rst_latency", lat, 4);
    check("post_rst_en_cycles", en_cyc, 3);
    check("post_rst_rdata", rd, 16'hBEBF);

    // Randomized traffic on instance 0 against a transaction-level model.
    last_rd[0] = 16'hBEBF;
    last_rd[1] = 16'h0000;
    pend = '{0, 0};
    age  = '{0, 0};
    for (int c = 0; c < 340; c++) begin
      @(negedge clk);
      check("rnd_ack_exclusive", p0_ack[0] && p1_ack[0], 0);
      check("rnd_oe_needs_en", sram_oe[0] && !sram_en[0], 0);
      for (int pi = 0; pi < 2; pi++) begin
        bit p;
        p = bit'(pi);
        if (pend[p]) age[p]++;
        if (get_ack(0, p)) begin
          check("rnd_ack_pending", pend[p], 1);
          if (pend[p]) begin
            check("rnd_latency_bound", (age[p] >= 4 && age[p] <= 9), 1);
            exp_v = rwr[p] ? last_rd[p] : ref_rd(raddr[p], ref_mem);
            check($sformatf("rnd_p%0d_rdata", pi), get_rdata(0, p), exp_v);
            if (rwr[p]) ref_mem[int'(raddr[p])] = rwd[p];
            else        last_rd[p] = exp_v;
          end
          pend[p] = 1'b0;
          set_req(0, p, 0, 0, 16'h0, 16'h0);
        end else if (pend[p] && age[p] > 9) begin
          check($sformatf("rnd_p%0d_timeout", pi), age[p], 9);
          pend[p] = 1'b0;
          set_req(0, p, 0, 0, 16'h0, 16'h0);
        end else if (!pend[p] && c < 300 && $urandom_range(0, 2) == 0) begin
          pend[p]  = 1'b1;
          age[p]   = 0;
          rwr[p]   = 1'($urandom_range(0, 1));
          raddr[p] = 16'h8000 | 16'($urandom_range(0, 15));
          rwd[p]   = 16'($urandom);
          set_req(0, p, 1'b1, rwr[p], raddr[p], rwd[p]);
        end
      end
    end
    check("rnd_drained", {pend[0], pend[1]}, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
